// File: rtl/sc_vel_sched.sv
// -----------------------------------------------------------------------------
// sc_vel_sched -- vehicle speed scheduler
//
// A single shared prescaler divides SC_VEL_CLOCK_50 down to a base tick. Each
// lane has a programmable period (in base ticks) and a down-counter that turns
// the base tick into a one-clock move pulse for that lane. The game FSM drives
// run/pause/stop sequencing and a level-up speed ramp that shortens every
// enabled lane period by one.
//
// Ports
//   SC_VEL_CLOCK_50   in   1        system clock (50 MHz)
//   SC_VEL_RESET      in   1        asynchronous reset, active high
//   SC_VEL_START      in   1        pulse, IDLE -> RUN
//   SC_VEL_PAUSE      in   1        level, motion held while high
//   SC_VEL_STOP       in   1        pulse, any state -> IDLE
//   SC_VEL_LEVEL_UP   in   1        pulse, speed ramp (RUN/PAUSE only)
//   SC_VEL_CFG_WE     in   1        period write strobe
//   SC_VEL_CFG_LANE   in   3        lane index for the write
//   SC_VEL_CFG_PER    in   PER_W    period value, 0 disables the lane
//   SC_VEL_TICK       out  LANES    per-lane move pulse, registered
//   SC_VEL_STATE      out  2        00 IDLE, 01 RUN, 10 PAUSE
//   SC_VEL_LEVEL      out  4        current level, saturates at 15
//
// States
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | stopped; prescaler and lane counters held at 0
//   RUN    | prescaler counting, lanes fire on base ticks
//   PAUSE  | prescaler and lane counters frozen, no pulses
// -----------------------------------------------------------------------------
module sc_vel_sched #(
  parameter int LANES       = 4,
  parameter int PRESC_W     = 20,
  parameter int PRESC_MAX   = 999999,
  parameter int PER_W       = 6,
  parameter int PER_DEFAULT = 8,
  parameter int PER_MIN     = 1
) (
  input  logic              SC_VEL_CLOCK_50,
  input  logic              SC_VEL_RESET,
  input  logic              SC_VEL_START,
  input  logic              SC_VEL_PAUSE,
  input  logic              SC_VEL_STOP,
  input  logic              SC_VEL_LEVEL_UP,
  input  logic              SC_VEL_CFG_WE,
  input  logic [2:0]        SC_VEL_CFG_LANE,
  input  logic [PER_W-1:0]  SC_VEL_CFG_PER,
  output logic [LANES-1:0]  SC_VEL_TICK,
  output logic [1:0]        SC_VEL_STATE,
  output logic [3:0]        SC_VEL_LEVEL
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam logic [PRESC_W-1:0] L_PRESC_MAX = PRESC_W'(PRESC_MAX);
  localparam logic [PRESC_W-1:0] L_PRESC_ONE = PRESC_W'(1);
  localparam logic [PER_W-1:0]   L_PER_DEF   = PER_W'(PER_DEFAULT);
  localparam logic [PER_W-1:0]   L_PER_MIN   = PER_W'(PER_MIN);
  localparam logic [PER_W-1:0]   L_PER_ONE   = PER_W'(1);
  localparam logic [PER_W-1:0]   L_PER_ZERO  = '0;
  localparam logic [3:0]         L_LVL_MAX   = 4'd15;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PRESC_W-1:0]   r_presc;
  logic [PER_W-1:0]     r_period [LANES];
  logic [PER_W-1:0]     r_count  [LANES];
  logic [LANES-1:0]     r_tick;
  logic [3:0]           r_level;

  logic                 w_start;
  logic                 w_base_tick;
  logic                 w_lvl_up;
  logic [LANES-1:0]     w_cfg_hit;
  logic [LANES-1:0]     w_fire;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and decoded strobes
  // STOP beats PAUSE beats START. A START arriving while PAUSE is already
  // high goes straight to PAUSE (counters still load).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    if (SC_VEL_STOP) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (SC_VEL_START) begin
            w_start     = 1'b1;
            w_state_nxt = SC_VEL_PAUSE ? ST_PAUSE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (SC_VEL_PAUSE) begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!SC_VEL_PAUSE) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // A STOP cycle never produces a base tick, so no pulse escapes on the way
  // back to IDLE.
  always_comb begin
    w_base_tick = 1'b0;
    if ((r_state == ST_RUN) && !SC_VEL_STOP && (r_presc == L_PRESC_MAX)) begin
      w_base_tick = 1'b1;
    end
  end

  always_comb begin
    w_lvl_up = 1'b0;
    if (SC_VEL_LEVEL_UP && (r_state != ST_IDLE)) begin
      w_lvl_up = 1'b1;
    end
  end

  // Out-of-range lane indices simply match no lane.
  always_comb begin
    w_cfg_hit = '0;
    for (int i = 0; i < LANES; i++) begin
      if (SC_VEL_CFG_WE && (SC_VEL_CFG_LANE == 3'(i))) begin
        w_cfg_hit[i] = 1'b1;
      end
    end
  end

  // A config write on the same lane as a base tick takes the reload slot, so
  // that lane stays quiet this cycle.
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_base_tick && !w_cfg_hit[i] &&
          (r_period[i] != L_PER_ZERO) && (r_count[i] <= L_PER_ONE)) begin
        w_fire[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: counts only in RUN, frozen in PAUSE, zero in IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      r_presc <= '0;
    end else if (SC_VEL_STOP || (r_state == ST_IDLE)) begin
      r_presc <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_presc == L_PRESC_MAX) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + L_PRESC_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lane periods, down-counters and registered move pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      for (int i = 0; i < LANES; i++) begin
        r_period[i] <= L_PER_DEF;
        r_count[i]  <= '0;
      end
      r_tick <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        // Period: an explicit write beats the level-up ramp on that lane.
        // Zero periods are never ramped; the floor check also keeps them there
        // when PER_MIN is 0.
        if (w_cfg_hit[i]) begin
          r_period[i] <= SC_VEL_CFG_PER;
        end else if (w_lvl_up && (r_period[i] != L_PER_ZERO) &&
                     (r_period[i] > L_PER_MIN)) begin
          r_period[i] <= r_period[i] - L_PER_ONE;
        end

        // Counter: a ramp does not touch it; the shorter period is picked up
        // at the next reload.
        if (w_cfg_hit[i]) begin
          r_count[i] <= SC_VEL_CFG_PER;
        end else if (SC_VEL_STOP) begin
          r_count[i] <= '0;
        end else if (w_start) begin
          r_count[i] <= r_period[i];
        end else if (w_base_tick) begin
          if (r_period[i] == L_PER_ZERO) begin
            r_count[i] <= '0;
          end else if (r_count[i] <= L_PER_ONE) begin
            r_count[i] <= r_period[i];
          end else begin
            r_count[i] <= r_count[i] - L_PER_ONE;
          end
        end
      end
      r_tick <= w_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Level counter, kept across STOP
  // ---------------------------------------------------------------------------
  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      r_level <= '0;
    end else if (w_lvl_up && (r_level != L_LVL_MAX)) begin
      r_level <= r_level + 4'd1;
    end
  end

  assign SC_VEL_TICK  = r_tick;
  assign SC_VEL_STATE = r_state;
  assign SC_VEL_LEVEL = r_level;

endmodule

// File: tb/tb_sc_vel_sched.sv
// -----------------------------------------------------------------------------
// tb_sc_vel_sched -- directed bench for sc_vel_sched
//
// Runs the scheduler with a 4-clock base tick (PRESC_MAX=3). Inputs change
// 1 ns after a rising edge; outputs are sampled at the same point, so what is
// seen after step k reflects the register update at edge k.
// -----------------------------------------------------------------------------
module tb_sc_vel_sched;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic       pause    = 1'b0;
  logic       stop     = 1'b0;
  logic       lvl_up   = 1'b0;
  logic       cfg_we   = 1'b0;
  logic [2:0] cfg_lane = 3'd0;
  logic [5:0] cfg_per  = 6'd0;
  logic [3:0] tick;
  logic [1:0] state;
  logic [3:0] level;

  int n_vec = 0;
  int n_err = 0;

  sc_vel_sched #(
    .LANES      (4),
    .PRESC_W    (20),
    .PRESC_MAX  (3),
    .PER_W      (6),
    .PER_DEFAULT(8),
    .PER_MIN    (1)
  ) dut (
    .SC_VEL_CLOCK_50(clk),
    .SC_VEL_RESET   (rst),
    .SC_VEL_START   (start),
    .SC_VEL_PAUSE   (pause),
    .SC_VEL_STOP    (stop),
    .SC_VEL_LEVEL_UP(lvl_up),
    .SC_VEL_CFG_WE  (cfg_we),
    .SC_VEL_CFG_LANE(cfg_lane),
    .SC_VEL_CFG_PER (cfg_per),
    .SC_VEL_TICK    (tick),
    .SC_VEL_STATE   (state),
    .SC_VEL_LEVEL   (level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start  = 1'b0;
    pause  = 1'b0;
    stop   = 1'b0;
    lvl_up = 1'b0;
    cfg_we = 1'b0;
    rst    = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] lane, input logic [5:0] per);
    cfg_we   = 1'b1;
    cfg_lane = lane;
    cfg_per  = per;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic set_periods(input logic [5:0] p0, input logic [5:0] p1,
                             input logic [5:0] p2, input logic [5:0] p3);
    cfg_write(3'd0, p0);
    cfg_write(3'd1, p1);
    cfg_write(3'd2, p2);
    cfg_write(3'd3, p3);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (state !== 2'b00) begin
      n_err++;
      $display("FAIL reset_state got %b want 00", state);
    end
    n_vec++;
    if (tick !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_tick got %b want 0000", tick);
    end
    n_vec++;
    if (level !== 4'd0) begin
      n_err++;
      $display("FAIL reset_level got %0d want 0", level);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++;
      if (tick !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_tick k=%0d got %b want 0000", k, tick);
      end
    end
  endtask

  // Periods {1,2,3,0}: base ticks land at edges 4,8,12,...
  task automatic test_rate();
    logic [3:0] exp_r [6];
    logic [3:0] exp_t;
    exp_r = '{4'b0001, 4'b0011, 4'b0101, 4'b0011, 4'b0001, 4'b0111};
    apply_reset();
    set_periods(6'd1, 6'd2, 6'd3, 6'd0);
    do_start();
    n_vec++;
    if (state !== 2'b01) begin
      n_err++;
      $display("FAIL rate_state got %b want 01", state);
    end
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_t = ((k % 4) == 0) ? exp_r[k/4 - 1] : 4'b0000;
      n_vec++;
      if (tick !== exp_t) begin
        n_err++;
        $display("FAIL rate_tick k=%0d got %b want %b", k, tick, exp_t);
      end
    end
  endtask

  // Ten PAUSE clocks push the first pulse from edge 4 to edge 14.
  task automatic test_pause();
    apply_reset();
    set_periods(6'd1, 6'd2, 6'd3, 6'd0);
    do_start();
    step();
    step();
    pause = 1'b1;
    for (int k = 3; k <= 12; k++) begin
      step();
      n_vec++;
      if (state !== 2'b10) begin
        n_err++;
        $display("FAIL pause_state k=%0d got %b want 10", k, state);
      end
      n_vec++;
      if (tick !== 4'b0000) begin
        n_err++;
        $display("FAIL pause_tick k=%0d got %b want 0000", k, tick);
      end
    end
    pause = 1'b0;
    step();
    n_vec++;
    if (state !== 2'b01 || tick !== 4'b0000) begin
      n_err++;
      $display("FAIL resume_e13 state=%b tick=%b want 01/0000", state, tick);
    end
    step();
    n_vec++;
    if (tick !== 4'b0001) begin
      n_err++;
      $display("FAIL resume_e14 tick=%b want 0001", tick);
    end
  endtask

  // Periods {3,3,1,0} ramped three times become {1,1,1,0}.
  task automatic test_level_up();
    apply_reset();
    set_periods(6'd3, 6'd3, 6'd1, 6'd0);
    do_start();
    for (int k = 1; k <= 24; k++) begin
      lvl_up = (k == 1 || k == 3 || k == 5);
      step();
      lvl_up = 1'b0;
      if (k == 6) begin
        n_vec++;
        if (level !== 4'd3) begin
          n_err++;
          $display("FAIL lvlup_level got %0d want 3", level);
        end
      end
      if (k == 16 || k == 20 || k == 24) begin
        n_vec++;
        if (tick !== 4'b0111) begin
          n_err++;
          $display("FAIL lvlup_tick k=%0d got %b want 0111", k, tick);
        end
      end
      if (k == 17 || k == 18 || k == 19) begin
        n_vec++;
        if (tick !== 4'b0000) begin
          n_err++;
          $display("FAIL lvlup_gap k=%0d got %b want 0000", k, tick);
        end
      end
    end
  endtask

  // Lane 1 rewritten to 5 on its firing base tick; lane 6 write must be inert.
  task automatic test_cfg_collision();
    logic [3:0] exp_c [7];
    logic [3:0] exp_t;
    exp_c = '{4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0001, 4'b0101, 4'b0011};
    apply_reset();
    set_periods(6'd1, 6'd2, 6'd3, 6'd0);
    do_start();
    for (int k = 1; k <= 28; k++) begin
      if (k == 8) begin
        cfg_we   = 1'b1;
        cfg_lane = 3'd1;
        cfg_per  = 6'd5;
      end
      if (k == 9) begin
        cfg_we   = 1'b1;
        cfg_lane = 3'd6;
        cfg_per  = 6'd0;
      end
      step();
      cfg_we = 1'b0;
      exp_t = ((k % 4) == 0) ? exp_c[k/4 - 1] : 4'b0000;
      n_vec++;
      if (tick !== exp_t) begin
        n_err++;
        $display("FAIL cfg_tick k=%0d got %b want %b", k, tick, exp_t);
      end
    end
  endtask

  task automatic test_level_sat();
    apply_reset();
    lvl_up = 1'b1;
    step();
    lvl_up = 1'b0;
    step();
    n_vec++;
    if (level !== 4'd0 || state !== 2'b00) begin
      n_err++;
      $display("FAIL idle_lvlup level=%0d state=%b want 0/00", level, state);
    end
    do_start();
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 28) begin
        n_vec++;
        if (tick !== 4'b0000) begin
          n_err++;
          $display("FAIL idle_lvlup_per k=28 got %b want 0000", tick);
        end
      end
      if (k == 32) begin
        n_vec++;
        if (tick !== 4'b1111) begin
          n_err++;
          $display("FAIL idle_lvlup_per k=32 got %b want 1111", tick);
        end
      end
    end
    for (int n = 1; n <= 16; n++) begin
      lvl_up = 1'b1;
      step();
      lvl_up = 1'b0;
      step();
      if (n == 1 || n == 15) begin
        n_vec++;
        if (level !== 4'(n)) begin
          n_err++;
          $display("FAIL lvl_count n=%0d got %0d want %0d", n, level, n);
        end
      end
    end
    n_vec++;
    if (level !== 4'd15) begin
      n_err++;
      $display("FAIL lvl_sat got %0d want 15", level);
    end
  endtask

  // Continues from test_level_sat: RUN, LEVEL=15, all periods ramped to 1.
  task automatic test_stop_reset();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_vec++;
    if (state !== 2'b00 || tick !== 4'b0000 || level !== 4'd15) begin
      n_err++;
      $display("FAIL stop state=%b tick=%b level=%0d want 00/0000/15",
               state, tick, level);
    end
    do_start();
    for (int k = 1; k <= 4; k++) step();
    n_vec++;
    if (tick !== 4'b1111) begin
      n_err++;
      $display("FAIL restart_tick got %b want 1111", tick);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (tick !== 4'b0000 || state !== 2'b00 || level !== 4'd0) begin
      n_err++;
      $display("FAIL async_rst tick=%b state=%b level=%0d want 0000/00/0",
               tick, state, level);
    end
    step();
    rst = 1'b0;
    do_start();
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 28) begin
        n_vec++;
        if (tick !== 4'b0000) begin
          n_err++;
          $display("FAIL rst_per k=28 got %b want 0000", tick);
        end
      end
      if (k == 32) begin
        n_vec++;
        if (tick !== 4'b1111) begin
          n_err++;
          $display("FAIL rst_per k=32 got %b want 1111", tick);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rate();
    test_pause();
    test_level_up();
    test_cfg_collision();
    test_level_sat();
    test_stop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
